// File: rtl/pause_fade_ctrl_if.sv
// Signal bundle between the user/OSD/core side and the pause/dim controller.
// master drives the user inputs and core video; slave is the controller.
interface pause_fade_ctrl_if #(
    parameter int unsigned RW   = 3,
    parameter int unsigned GW   = 3,
    parameter int unsigned BW   = 2,
    parameter int unsigned NREQ = 2
);
    logic                  user_button;
    logic [NREQ-1:0]       pause_request;
    logic                  osd_status;
    logic [1:0]            options;
    logic [RW-1:0]         r;
    logic [GW-1:0]         g;
    logic [BW-1:0]         b;
    logic                  pause_cpu;
    logic                  user_paused;
    logic [2:0]            dim_level;
    logic [RW+GW+BW-1:0]   rgb_out;

    modport master (
        output user_button, pause_request, osd_status, options, r, g, b,
        input  pause_cpu, user_paused, dim_level, rgb_out
    );

    modport slave (
        input  user_button, pause_request, osd_status, options, r, g, b,
        output pause_cpu, user_paused, dim_level, rgb_out
    );
endinterface

// File: rtl/pause_fade_ctrl.sv
// Pause/dim controller: merges the user toggle, external pause requests and OSD state
// into one registered pause, and fades the video down while the user holds pause.
module pause_fade_ctrl #(
    parameter int unsigned RW        = 3,
    parameter int unsigned GW        = 3,
    parameter int unsigned BW        = 2,
    parameter int unsigned NREQ      = 2,
    parameter int unsigned DIM_DELAY = 480_000_000,
    parameter int unsigned FADE_STEP = 4_800_000,
    parameter int unsigned DIM_SHIFT = 2
) (
    input logic              clk_sys,
    input logic              reset_n,
    pause_fade_ctrl_if.slave bus
);

    localparam int unsigned CntMax = (DIM_DELAY > FADE_STEP) ? DIM_DELAY : FADE_STEP;
    localparam int unsigned CW     = $clog2(CntMax) + 1;
    localparam int unsigned OutW   = RW + GW + BW;

    localparam logic [CW-1:0] DelayLast = CW'(DIM_DELAY - 1);
    localparam logic [CW-1:0] FadeLast  = CW'(FADE_STEP - 1);
    localparam logic [2:0]    DimFinal  = 3'(DIM_SHIFT);

    typedef enum logic [1:0] {StRun, StWait, StFade, StDim} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      dim_q;
    logic            user_paused_q;
    logic            btn_q;
    logic            pause_cpu_q;
    logic [OutW-1:0] rgb_q;

    logic            rise;
    logic [NREQ-1:0] req;
    logic [RW-1:0]   r_dim;
    logic [GW-1:0]   g_dim;
    logic [BW-1:0]   b_dim;

    assign rise  = bus.user_button & ~btn_q;
    assign req   = bus.pause_request;
    // Logical shift: an amount >= channel width naturally gives zero.
    assign r_dim = bus.r >> dim_q;
    assign g_dim = bus.g >> dim_q;
    assign b_dim = bus.b >> dim_q;

    // User toggle and dim FSM; priority is rise, then dim-enable drop, then terminal count.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q       <= StRun;
            cnt_q         <= '0;
            dim_q         <= '0;
            user_paused_q <= 1'b0;
        end else if (rise) begin
            user_paused_q <= ~user_paused_q;
            state_q       <= (state_q == StRun) ? StWait : StRun;
            cnt_q         <= '0;
            dim_q         <= '0;
        end else if (state_q != StRun && !bus.options[1]) begin
            // Dimming disabled while paused: park in WAIT with the counter held.
            state_q <= StWait;
            cnt_q   <= '0;
            dim_q   <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    dim_q <= '0;
                end
                StWait: begin
                    if (cnt_q == DelayLast) begin
                        state_q <= (DimFinal == 3'd1) ? StDim : StFade;
                        cnt_q   <= '0;
                        dim_q   <= 3'd1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StFade: begin
                    if (cnt_q == FadeLast) begin
                        cnt_q <= '0;
                        dim_q <= dim_q + 3'd1;
                        if (dim_q + 3'd1 == DimFinal) begin
                            state_q <= StDim;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDim: begin
                    dim_q <= DimFinal;
                end
            endcase
        end
    end

    // Button history, merged pause and dimmed video, all registered.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            btn_q       <= 1'b0;
            pause_cpu_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            btn_q       <= bus.user_button;
            pause_cpu_q <= user_paused_q | (|req) | (bus.options[0] & bus.osd_status);
            rgb_q       <= {r_dim, g_dim, b_dim};
        end
    end

    assign bus.pause_cpu   = pause_cpu_q;
    assign bus.user_paused = user_paused_q;
    assign bus.dim_level   = dim_q;
    assign bus.rgb_out     = rgb_q;

endmodule
